// File: rtl/rf_sequencer.sv
// rf_sequencer: runs single register-file commands (CLR/LDI/INC/DEC/MOV/SWAP).
// It drives the read selects and write enables of an external register file.
// Optional feature: define RF_SEQUENCER_SWAP_EN to build the SWAP path
// (the WRITE2 state and the hold2 capture). When the macro is undefined,
// op 111 finishes through DONE with err=1 and writes nothing.
module rf_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_dst,
  input  logic [2:0] cmd_src,
  input  logic [7:0] cmd_imm,
  input  logic [7:0] rf_o1,
  input  logic [7:0] rf_o2,
  output logic [2:0] O1Sel,
  output logic [2:0] O2Sel,
  output logic [1:0] FunSel,
  output logic [3:0] RSel,
  output logic [3:0] TSel,
  output logic [7:0] i,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b111;

  localparam logic [1:0] FUN_DEC = 2'b00;
  localparam logic [1:0] FUN_INC = 2'b01;
  localparam logic [1:0] FUN_LD  = 2'b10;
  localparam logic [1:0] FUN_CLR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
`ifdef RF_SEQUENCER_SWAP_EN
    WRITE2,
`endif
    DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] op_reg, dst_reg, src_reg;
  logic [7:0] imm_reg;
  logic [7:0] hold1_reg;
  logic [1:0] funsel_reg;
  logic [7:0] i_reg;
  logic [2:0] o1sel_reg, o2sel_reg;
  logic       illegal_op;

`ifdef RF_SEQUENCER_SWAP_EN
  logic [7:0] hold2_reg;
`else
  // Without SWAP the second read port data has no consumer.
  logic unused_rf_o2;
  assign unused_rf_o2 = ^rf_o2;
`endif

  // One-hot lane within a bank: index 0 maps to the MSB (R1/T1).
  function automatic logic [3:0] lane(input logic [2:0] idx);
    return 4'b1000 >> idx[1:0];
  endfunction

  // Op 110 is always illegal; 111 is illegal only when SWAP is not built.
`ifdef RF_SEQUENCER_SWAP_EN
  assign illegal_op = (op_reg == 3'b110);
`else
  assign illegal_op = (op_reg == 3'b110) || (op_reg == OP_SWAP);
`endif

  // State, captured command, read holds and the "last value" copies of outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= 3'd0;
      dst_reg    <= 3'd0;
      src_reg    <= 3'd0;
      imm_reg    <= 8'd0;
      hold1_reg  <= 8'd0;
      funsel_reg <= 2'b00;
      i_reg      <= 8'd0;
      o1sel_reg  <= 3'd0;
      o2sel_reg  <= 3'd0;
`ifdef RF_SEQUENCER_SWAP_EN
      hold2_reg  <= 8'd0;
`endif
    end else begin
      state_reg  <= state_next;
      funsel_reg <= FunSel;
      i_reg      <= i;
      o1sel_reg  <= O1Sel;
      o2sel_reg  <= O2Sel;
      if (state_reg == IDLE && cmd_valid) begin
        op_reg  <= cmd_op;
        dst_reg <= cmd_dst;
        src_reg <= cmd_src;
        imm_reg <= cmd_imm;
      end
      // Read data is valid one cycle after the selects, i.e. during WAIT.
      if (state_reg == WAIT) begin
        hold1_reg <= rf_o1;
`ifdef RF_SEQUENCER_SWAP_EN
        hold2_reg <= rf_o2;
`endif
      end
    end
  end

  // Next-state and output decode; selects, FunSel and i default to their held values.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    RSel       = 4'b0000;
    TSel       = 4'b0000;
    FunSel     = funsel_reg;
    i          = i_reg;
    O1Sel      = o1sel_reg;
    O2Sel      = o2sel_reg;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLR, OP_LDI, OP_INC, OP_DEC: state_next = WRITE;
            OP_MOV:                         state_next = READ;
`ifdef RF_SEQUENCER_SWAP_EN
            OP_SWAP:                        state_next = READ;
`endif
            default:                        state_next = DONE;
          endcase
        end
      end
      READ: begin
        O1Sel      = src_reg;
        O2Sel      = dst_reg;
        state_next = WAIT;
      end
      WAIT: state_next = WRITE;
      WRITE: begin
        if (dst_reg[2]) RSel = lane(dst_reg);
        else            TSel = lane(dst_reg);
        case (op_reg)
          OP_CLR: FunSel = FUN_CLR;
          OP_LDI: begin FunSel = FUN_LD; i = imm_reg; end
          OP_INC: FunSel = FUN_INC;
          OP_DEC: FunSel = FUN_DEC;
          default: begin FunSel = FUN_LD; i = hold1_reg; end
        endcase
`ifdef RF_SEQUENCER_SWAP_EN
        state_next = (op_reg == OP_SWAP) ? WRITE2 : DONE;
`else
        state_next = DONE;
`endif
      end
`ifdef RF_SEQUENCER_SWAP_EN
      WRITE2: begin
        if (src_reg[2]) RSel = lane(src_reg);
        else            TSel = lane(src_reg);
        FunSel     = FUN_LD;
        i          = hold2_reg;
        state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        err        = illegal_op;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: directed self-checking bench for rf_sequencer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rf_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op, cmd_dst, cmd_src;
  logic [7:0] cmd_imm, rf_o1, rf_o2;
  logic [2:0] O1Sel, O2Sel;
  logic [1:0] FunSel;
  logic [3:0] RSel, TSel;
  logic [7:0] i;
  logic       done, err;

  int n_checks = 0;
  int n_pass   = 0;

  rf_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .rf_o1(rf_o1), .rf_o2(rf_o2), .O1Sel(O1Sel), .O2Sel(O2Sel),
    .FunSel(FunSel), .RSel(RSel), .TSel(TSel), .i(i), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] dst,
                       input logic [2:0] src, input logic [7:0] imm);
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src   = src;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_imm = 8'd0;
    rf_o1 = 8'd0; rf_o2 = 8'd0;

    // Reset state
    tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rsel", RSel, 0);
    chk("rst_tsel", TSel, 0);
    chk("rst_funsel", FunSel, 0);
    chk("rst_o1sel", O1Sel, 0);
    chk("rst_o2sel", O2Sel, 0);
    chk("rst_i", i, 0);
    rst = 1'b0;
    tick();

    // LDI dst=4 imm=5A
    issue(3'b010, 3'd4, 3'd0, 8'h5A);
    tick(); cmd_valid = 1'b0;
    chk("ldi_c1_rsel", RSel, 4'b1000);
    chk("ldi_c1_tsel", TSel, 4'b0000);
    chk("ldi_c1_funsel", FunSel, 2'b10);
    chk("ldi_c1_i", i, 8'h5A);
    chk("ldi_c1_ready", cmd_ready, 0);
    chk("ldi_c1_done", done, 0);
    tick();
    chk("ldi_c2_rsel", RSel, 4'b0000);
    chk("ldi_c2_done", done, 1);
    chk("ldi_c2_err", err, 0);
    chk("ldi_c2_i_held", i, 8'h5A);
    tick();
    chk("ldi_c3_done", done, 0);
    chk("ldi_c3_ready", cmd_ready, 1);

    // MOV src=0 dst=7, C3 presented only during WAIT
    issue(3'b101, 3'd7, 3'd0, 8'h00);
    tick(); cmd_valid = 1'b0; rf_o1 = 8'h00;
    chk("mov_c1_o1sel", O1Sel, 3'd0);
    chk("mov_c1_o2sel", O2Sel, 3'd7);
    chk("mov_c1_rsel", RSel, 4'b0000);
    tick(); rf_o1 = 8'hC3;
    chk("mov_c2_rsel", RSel, 4'b0000);
    chk("mov_c2_done", done, 0);
    tick(); rf_o1 = 8'hFF;
    chk("mov_c3_rsel", RSel, 4'b0001);
    chk("mov_c3_tsel", TSel, 4'b0000);
    chk("mov_c3_funsel", FunSel, 2'b10);
    chk("mov_c3_i", i, 8'hC3);
    tick();
    chk("mov_c4_done", done, 1);
    chk("mov_c4_rsel", RSel, 4'b0000);
    chk("mov_c4_o2sel_held", O2Sel, 3'd7);
    tick();

`ifdef RF_SEQUENCER_SWAP_EN
    // SWAP src=5 dst=1
    issue(3'b111, 3'd1, 3'd5, 8'h00);
    tick(); cmd_valid = 1'b0;
    chk("swap_c1_o1sel", O1Sel, 3'd5);
    chk("swap_c1_o2sel", O2Sel, 3'd1);
    tick(); rf_o1 = 8'h11; rf_o2 = 8'h22;
    tick(); rf_o1 = 8'h00; rf_o2 = 8'h00;
    chk("swap_c3_tsel", TSel, 4'b0100);
    chk("swap_c3_rsel", RSel, 4'b0000);
    chk("swap_c3_i", i, 8'h11);
    chk("swap_c3_funsel", FunSel, 2'b10);
    tick();
    chk("swap_c4_rsel", RSel, 4'b0100);
    chk("swap_c4_tsel", TSel, 4'b0000);
    chk("swap_c4_i", i, 8'h22);
    tick();
    chk("swap_c5_done", done, 1);
    chk("swap_c5_err", err, 0);
    tick();
`else
    // op 111 without SWAP support: NOP path with err
    issue(3'b111, 3'd1, 3'd5, 8'h00);
    tick(); cmd_valid = 1'b0;
    chk("op7_c1_done", done, 1);
    chk("op7_c1_err", err, 1);
    chk("op7_c1_rsel", RSel, 4'b0000);
    chk("op7_c1_tsel", TSel, 4'b0000);
    tick();
    chk("op7_c2_err", err, 0);
`endif

    // Reserved op 110
    issue(3'b110, 3'd3, 3'd0, 8'h00);
    tick(); cmd_valid = 1'b0;
    chk("op6_c1_done", done, 1);
    chk("op6_c1_err", err, 1);
    chk("op6_c1_tsel", TSel, 4'b0000);
    tick();

    // NOP
    issue(3'b000, 3'd3, 3'd0, 8'h00);
    tick(); cmd_valid = 1'b0;
    chk("nop_c1_done", done, 1);
    chk("nop_c1_err", err, 0);
    chk("nop_c1_tsel", TSel, 4'b0000);
    tick();

    // Back-to-back INC dst=2 then DEC dst=2 with cmd_valid held high
    issue(3'b011, 3'd2, 3'd0, 8'h00);
    tick();
    issue(3'b100, 3'd2, 3'd0, 8'h00);
    chk("b2b_c1_tsel", TSel, 4'b0010);
    chk("b2b_c1_funsel", FunSel, 2'b01);
    tick();
    chk("b2b_c2_done", done, 1);
    chk("b2b_c2_ready", cmd_ready, 0);
    tick();
    chk("b2b_c3_ready", cmd_ready, 1);
    chk("b2b_c3_tsel", TSel, 4'b0000);
    tick(); cmd_valid = 1'b0;
    chk("b2b_c4_tsel", TSel, 4'b0010);
    chk("b2b_c4_funsel", FunSel, 2'b00);
    tick();
    chk("b2b_c5_done", done, 1);
    tick();
    chk("b2b_c6_ready", cmd_ready, 1);

    // Reset during WAIT of MOV src=1 dst=6
    issue(3'b101, 3'd6, 3'd1, 8'h00);
    tick(); cmd_valid = 1'b0;
    chk("rmov_c1_o1sel", O1Sel, 3'd1);
    tick(); rst = 1'b1; rf_o1 = 8'hAA;
    tick(); rst = 1'b0;
    chk("rmov_ready", cmd_ready, 1);
    chk("rmov_rsel", RSel, 4'b0000);
    chk("rmov_tsel", TSel, 4'b0000);
    chk("rmov_done", done, 0);
    chk("rmov_o1sel", O1Sel, 3'd0);
    chk("rmov_i", i, 8'h00);
    tick();
    chk("rmov_n_rsel", RSel, 4'b0000);
    chk("rmov_n_done", done, 0);

    // Command presented together with reset is not accepted
    rst = 1'b1;
    issue(3'b010, 3'd4, 3'd0, 8'h77);
    tick(); rst = 1'b0; cmd_valid = 1'b0;
    chk("rcmd_ready", cmd_ready, 1);
    chk("rcmd_rsel", RSel, 4'b0000);
    tick();
    chk("rcmd_n_done", done, 0);
    chk("rcmd_n_i", i, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk is the single clock (rising edge), and rst is the synchronous, active-high reset.
REQ-002 The module SHALL have these ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 000 NOP, 001 CLR, 010 LDI, 011 INC, 100 DEC, 101 MOV, 110 reserved, 111 SWAP.
- cmd_dst  in  3  destination register index.
- cmd_src  in  3  source register index.
- cmd_imm  in  8  immediate for LDI.
- rf_o1  in  8  register-file read port 1 data.
- rf_o2  in  8  register-file read port 2 data.
- O1Sel  out  3  read port 1 select.
- O2Sel  out  3  read port 2 select.
- FunSel  out  2  register function.
- RSel  out  4  R1..R4 enables, MSB = R1.
- TSel  out  4  T1..T4 enables, MSB = T1.
- i  out  8  write data to the register file.
- done  out  1  one-cycle command-complete pulse.
- err  out  1  one-cycle pulse, concurrent with done, for an illegal op.

Function
REQ-003 Register index encoding SHALL be: 0..3 = T1..T4 and 4..7 = R1..R4. The same encoding SHALL apply to O1Sel and O2Sel.
REQ-004 FunSel encoding SHALL be: 00 decrement, 01 increment, 10 load, 11 clear.
REQ-005 The state machine SHALL have the states IDLE, READ, WAIT, WRITE, WRITE2 and DONE.
REQ-006 cmd_ready SHALL be 1 only in IDLE. A command SHALL be accepted on the edge where cmd_valid and cmd_ready are both 1, and all cmd_* fields SHALL be captured on that edge.
REQ-007 State transitions SHALL be:
- CLR, LDI, INC and DEC: IDLE->WRITE->DONE->IDLE, so done is asserted 2 cycles after acceptance.
- NOP and reserved: IDLE->DONE->IDLE.
- MOV: IDLE->READ->WAIT->WRITE->DONE->IDLE.
- SWAP: IDLE->READ->WAIT->WRITE->WRITE2->DONE->IDLE.
REQ-008 In READ, the module SHALL drive O1Sel=src and O2Sel=dst. O1Sel and O2Sel SHALL otherwise hold their last values.
REQ-009 At the end of WAIT, the module SHALL capture rf_o1 into hold1 and rf_o2 into hold2, which covers the register file's one-cycle registered read latency.
REQ-010 In WRITE, the module SHALL assert exactly one enable bit, decoded from dst, for exactly one cycle, with FunSel per op:
- CLR: 11.
- LDI: 10 with i=imm.
- INC: 01.
- DEC: 00.
- MOV: 10 with i=hold1.
- SWAP: 10 with i=hold1.
REQ-011 In WRITE2 (SWAP only), the module SHALL assert the enable bit for src with FunSel=10 and i=hold2.
REQ-012 Outside WRITE and WRITE2, RSel and TSel SHALL be 0000. FunSel and i SHALL hold their last values.
REQ-013 done SHALL be 1 only in DONE. err SHALL be 1 only in DONE after op 110, or after op 111 when SWAP is compiled out.
REQ-014 No register SHALL be written for NOP or for any illegal op.
REQ-015 MOV or SWAP with src==dst SHALL execute normally. For SWAP this yields a single-register rewrite of the original value.
REQ-016 cmd_valid during a busy state SHALL be ignored and SHALL NOT be captured.
REQ-017 The module SHALL be able to accept a new command on the cycle after DONE.

Reset
REQ-018 On rst=1 at a clock edge, the module SHALL set: state=IDLE, cmd_ready=1, done=0, err=0, RSel=0000, TSel=0000, FunSel=00, O1Sel=000, O2Sel=000, i=00, hold1=00, hold2=00.
REQ-019 Reset SHALL take precedence over all activity. A reset mid-command SHALL abort it and suppress any pending write enable or done pulse.
REQ-020 A command presented with rst=1 SHALL NOT be accepted.

Configuration
REQ-021 The macro RF_SEQUENCER_SWAP_EN SHALL control SWAP support:
- Defined: op 111 executes SWAP per REQ-007 and REQ-011.
- Undefined: the WRITE2 state and hold2 capture are omitted, and op 111 follows the NOP path with err=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- LDI: LDI dst=4, imm=8'h5A -> RSel=1000 and FunSel=10 with i=5A for 1 cycle in cycle 1 after acceptance; done in cycle 2.
- MOV: MOV src=0, dst=7 with rf_o1=8'hC3 during WAIT -> RSel=0001, FunSel=10, i=C3 in cycle 3; done in cycle 4; O1Sel=000 from cycle 1.
- SWAP: SWAP src=5, dst=1, macro defined, rf_o1=11, rf_o2=22 -> WRITE: TSel=0100 with i=11; WRITE2: RSel=0100 with i=22; done in cycle 5.
- Macro undefined: op 111 -> no enables asserted; done=1 and err=1 in cycle 1.
- Reset mid-operation: rst asserted during the WAIT state of a MOV -> next cycle IDLE, cmd_ready=1, no enable pulse, no done.
- Back-to-back commands: cmd_valid held high for INC dst=2 then DEC dst=2 -> TSel=0010 with FunSel=01, then TSel=0010 with FunSel=00; second acceptance on the cycle after the first done.
